// File: rtl/crc32_frame_check.sv
// crc32_frame_check
//
// Receive-side CRC-32 checker for a byte stream. Each frame ends with a
// 4-byte FCS, LSB byte first. The block strips the FCS, forwards the payload
// bytes and reports a good/bad status for every frame. There is no
// backpressure. Every output is registered, so a response appears one cycle
// after the byte that caused it.
//
// Parameters
//   POLY       reflected CRC polynomial
//   INIT       CRC seed, loaded at reset and after every frame
//   RESIDUE    register value after data+FCS of a good frame (no final XOR)
//   STRIP_FCS  1: hold back the last 4 bytes of each frame; 0: forward every byte
//   CNT_W      width of the saturating good/bad frame counters
//
// Ports
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   valid_i     data_i carries a byte this cycle
//   data_i      received byte (frame bytes, then FCS bytes)
//   last_i      marks the final byte of the frame (the last FCS byte)
//   valid_o     data_o carries a payload byte
//   data_o      payload byte
//   last_o      data_o is the last payload byte of the frame
//   done_o      one-cycle pulse: frame status is valid
//   crc_ok_o    CRC residue matched (updated with done_o, held otherwise)
//   len_err_o   frame too short (updated with done_o, held otherwise)
//   good_cnt_o  count of frames with crc_ok, saturating
//   bad_cnt_o   count of frames with a CRC or length error, saturating

module crc32_frame_check #(
    parameter logic [31:0] POLY      = 32'hEDB88320,
    parameter logic [31:0] INIT      = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE   = 32'hDEBB20E3,
    parameter bit          STRIP_FCS = 1'b1,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    input  logic [7:0]       data_i,
    input  logic             last_i,
    output logic             valid_o,
    output logic [7:0]       data_o,
    output logic             last_o,
    output logic             done_o,
    output logic             crc_ok_o,
    output logic             len_err_o,
    output logic [CNT_W-1:0] good_cnt_o,
    output logic [CNT_W-1:0] bad_cnt_o
);

    localparam logic [CNT_W-1:0] CntOne = 1;
    localparam logic [CNT_W-1:0] CntMax = '1;

    // Number of frame bytes seen so far, saturating at four. With STRIP_FCS
    // this is also the fill level of the delay buffer.
    typedef enum logic [2:0] {
        StFill0,
        StFill1,
        StFill2,
        StFill3,
        StFill4
    } fill_e;

    fill_e            state_q, state_d;
    logic [31:0]      crc_q, crc_d;
    logic [7:0]       dly_q [4];
    logic [7:0]       dly_d [4];
    logic             valid_q, valid_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic             done_q, done_d;
    logic             crc_ok_q, crc_ok_d;
    logic             len_err_q, len_err_d;
    logic [CNT_W-1:0] good_q, good_d;
    logic [CNT_W-1:0] bad_q, bad_d;

    logic [31:0]      crc_upd;
    logic             full;
    logic             short_frame;

    // Advance the CRC by one byte: eight serial steps, LSB first.
    function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d_in);
        logic [31:0] c;
        logic [7:0]  d;
        c = c_in;
        d = d_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[0]) begin
                c = (c >> 1) ^ POLY;
            end else begin
                c = c >> 1;
            end
            d = d >> 1;
        end
        return c;
    endfunction

    always_comb begin
        crc_upd = crc_byte(crc_q, data_i);
        full    = (state_q == StFill4);

        // Judged at the last byte, before this byte is counted. With
        // stripping, a frame of four bytes or fewer has no payload. Without
        // stripping, a frame of fewer than four bytes cannot hold an FCS.
        if (STRIP_FCS) begin
            short_frame = !full;
        end else begin
            short_frame = (state_q == StFill0) || (state_q == StFill1) ||
                          (state_q == StFill2);
        end

        state_d   = state_q;
        crc_d     = crc_q;
        dly_d     = dly_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        last_d    = 1'b0;
        done_d    = 1'b0;
        crc_ok_d  = crc_ok_q;
        len_err_d = len_err_q;
        good_d    = good_q;
        bad_d     = bad_q;

        if (valid_i) begin
            crc_d = crc_upd;

            // Shift register: entry 3 holds the oldest byte once the buffer is full.
            dly_d[0] = data_i;
            dly_d[1] = dly_q[0];
            dly_d[2] = dly_q[1];
            dly_d[3] = dly_q[2];

            if (STRIP_FCS) begin
                if (full) begin
                    valid_d = 1'b1;
                    data_d  = dly_q[3];
                    last_d  = last_i;
                end
            end else begin
                valid_d = 1'b1;
                data_d  = data_i;
                last_d  = last_i;
            end

            unique case (state_q)
                StFill0: state_d = StFill1;
                StFill1: state_d = StFill2;
                StFill2: state_d = StFill3;
                StFill3: state_d = StFill4;
                StFill4: state_d = StFill4;
                default: state_d = StFill0;
            endcase

            if (last_i) begin
                state_d   = StFill0;
                crc_d     = INIT;
                done_d    = 1'b1;
                len_err_d = short_frame;
                crc_ok_d  = !short_frame && (crc_upd == RESIDUE);
                if (crc_ok_d) begin
                    if (good_q != CntMax) begin
                        good_d = good_q + CntOne;
                    end
                end else begin
                    if (bad_q != CntMax) begin
                        bad_d = bad_q + CntOne;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFill0;
            crc_q     <= INIT;
            dly_q     <= '{default: 8'h00};
            valid_q   <= 1'b0;
            data_q    <= 8'h00;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            crc_ok_q  <= 1'b0;
            len_err_q <= 1'b0;
            good_q    <= '0;
            bad_q     <= '0;
        end else begin
            state_q   <= state_d;
            crc_q     <= crc_d;
            dly_q     <= dly_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            last_q    <= last_d;
            done_q    <= done_d;
            crc_ok_q  <= crc_ok_d;
            len_err_q <= len_err_d;
            good_q    <= good_d;
            bad_q     <= bad_d;
        end
    end

    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign last_o     = last_q;
    assign done_o     = done_q;
    assign crc_ok_o   = crc_ok_q;
    assign len_err_o  = len_err_q;
    assign good_cnt_o = good_q;
    assign bad_cnt_o  = bad_q;

endmodule

// File: tb/tb_crc32_frame_check.sv
// Directed bench for crc32_frame_check. Three instances share one input
// stream: A uses the default parameters, B has CNT_W=2 and C has
// STRIP_FCS=0. The bench checks every output after each clock edge.

module tb_crc32_frame_check;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    logic       last;

    always #5 clk = ~clk;

    logic        a_valid, a_last, a_done, a_ok, a_lerr;
    logic [7:0]  a_data;
    logic [15:0] a_good, a_bad;
    logic        b_valid, b_last, b_done, b_ok, b_lerr;
    logic [7:0]  b_data;
    logic [1:0]  b_good, b_bad;
    logic        c_valid, c_last, c_done, c_ok, c_lerr;
    logic [7:0]  c_data;
    logic [15:0] c_good, c_bad;

    crc32_frame_check u_a (
        .clk(clk), .rst(rst), .valid_i(valid), .data_i(data), .last_i(last),
        .valid_o(a_valid), .data_o(a_data), .last_o(a_last), .done_o(a_done),
        .crc_ok_o(a_ok), .len_err_o(a_lerr), .good_cnt_o(a_good), .bad_cnt_o(a_bad)
    );

    crc32_frame_check #(.CNT_W(2)) u_b (
        .clk(clk), .rst(rst), .valid_i(valid), .data_i(data), .last_i(last),
        .valid_o(b_valid), .data_o(b_data), .last_o(b_last), .done_o(b_done),
        .crc_ok_o(b_ok), .len_err_o(b_lerr), .good_cnt_o(b_good), .bad_cnt_o(b_bad)
    );

    crc32_frame_check #(.STRIP_FCS(1'b0)) u_c (
        .clk(clk), .rst(rst), .valid_i(valid), .data_i(data), .last_i(last),
        .valid_o(c_valid), .data_o(c_data), .last_o(c_last), .done_o(c_done),
        .crc_ok_o(c_ok), .len_err_o(c_lerr), .good_cnt_o(c_good), .bad_cnt_o(c_bad)
    );

    int n_vec = 0;
    int n_err = 0;

    // Expected counter values.
    int eg_a, eb_a, eg_b, eb_b, eg_c, eb_c;

    // "123456789" followed by its FCS (CRC-32 check value 0xCBF43926, LSB first).
    logic [7:0] frame1 [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38,
                                8'h39, 8'h26, 8'h39, 8'hF4, 8'hCB};
    logic [7:0] frame_bad [13];
    logic [7:0] frame_short [13] = '{8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00, 8'h00, 8'h00,
                                     8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_counts();
        chk("a_good_cnt", 32'(a_good), 32'(eg_a));
        chk("a_bad_cnt",  32'(a_bad),  32'(eb_a));
        chk("b_good_cnt", 32'(b_good), 32'(eg_b));
        chk("b_bad_cnt",  32'(b_bad),  32'(eb_b));
        chk("c_good_cnt", 32'(c_good), 32'(eg_c));
        chk("c_bad_cnt",  32'(c_bad),  32'(eb_c));
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        last  = 1'b0;
        data  = 8'h00;
        @(posedge clk);
        #1;
        rst = 1'b0;
        eg_a = 0; eb_a = 0; eg_b = 0; eb_b = 0; eg_c = 0; eb_c = 0;
        chk("rst_a_valid", 32'(a_valid), 32'd0);
        chk("rst_a_data",  32'(a_data),  32'd0);
        chk("rst_a_last",  32'(a_last),  32'd0);
        chk("rst_a_done",  32'(a_done),  32'd0);
        chk("rst_a_ok",    32'(a_ok),    32'd0);
        chk("rst_a_lerr",  32'(a_lerr),  32'd0);
        chk("rst_c_valid", 32'(c_valid), 32'd0);
        chk("rst_c_done",  32'(c_done),  32'd0);
        check_counts();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            valid = 1'b0;
            last  = 1'b0;
            @(posedge clk);
            #1;
            chk("idle_a_valid", 32'(a_valid), 32'd0);
            chk("idle_a_done",  32'(a_done),  32'd0);
            chk("idle_c_valid", 32'(c_valid), 32'd0);
        end
    endtask

    // Sends bytes 0..nsend-1 of a frame that is len bytes long. last_i is
    // raised only if byte len-1 is sent. exp_ok is the CRC verdict for a
    // frame long enough to be checked.
    task automatic send_frame(input logic [7:0] f [13], input int len, input int nsend,
                              input bit gaps, input bit exp_ok);
        bit ok_a, ok_c, is_last, ev_a;
        for (int i = 0; i < nsend; i++) begin
            if (gaps) begin
                // Idle cycle with junk on data/last; the DUT must ignore it.
                while ($urandom_range(0, 1) == 1) begin
                    valid = 1'b0;
                    data  = 8'($urandom);
                    last  = 1'($urandom);
                    @(posedge clk);
                    #1;
                    chk("gap_a_valid", 32'(a_valid), 32'd0);
                    chk("gap_a_last",  32'(a_last),  32'd0);
                    chk("gap_a_done",  32'(a_done),  32'd0);
                    chk("gap_c_valid", 32'(c_valid), 32'd0);
                end
            end
            is_last = (i == len - 1);
            valid = 1'b1;
            data  = f[i];
            last  = is_last;
            @(posedge clk);
            #1;
            // A: payload byte i-4 comes out once four bytes are buffered.
            ev_a = (len >= 5) && (i >= 4);
            chk("a_valid", 32'(a_valid), 32'(ev_a));
            if (ev_a) chk("a_data", 32'(a_data), 32'(f[i-4]));
            chk("a_last", 32'(a_last), 32'(ev_a && is_last));
            chk("a_done", 32'(a_done), 32'(is_last));
            // C: every byte goes straight through.
            chk("c_valid", 32'(c_valid), 32'd1);
            chk("c_data",  32'(c_data),  32'(f[i]));
            chk("c_last",  32'(c_last),  32'(is_last));
            chk("c_done",  32'(c_done),  32'(is_last));
            if (is_last) begin
                ok_a = exp_ok && (len >= 5);
                ok_c = exp_ok && (len >= 4);
                chk("a_crc_ok",  32'(a_ok),   32'(ok_a));
                chk("a_len_err", 32'(a_lerr), 32'(len < 5));
                chk("b_crc_ok",  32'(b_ok),   32'(ok_a));
                chk("c_crc_ok",  32'(c_ok),   32'(ok_c));
                chk("c_len_err", 32'(c_lerr), 32'(len < 4));
                if (ok_a) begin
                    eg_a++;
                    if (eg_b < 3) eg_b++;
                end else begin
                    eb_a++;
                    if (eb_b < 3) eb_b++;
                end
                if (ok_c) eg_c++;
                else eb_c++;
            end
        end
    endtask

    initial begin
        frame_bad    = frame1;
        frame_bad[4] = 8'h36;

        // Reset state.
        do_reset();

        // Good frame "123456789".
        send_frame(frame1, 13, 13, 1'b0, 1'b1);
        idle(1);
        check_counts();

        // Byte 35 corrupted to 36.
        do_reset();
        send_frame(frame_bad, 13, 13, 1'b0, 1'b0);
        idle(1);
        check_counts();

        // Three-byte frame: too short, no payload.
        do_reset();
        send_frame(frame_short, 3, 3, 1'b0, 1'b0);
        idle(1);
        check_counts();
        // Status holds until the next frame completes.
        chk("hold_a_len_err", 32'(a_lerr), 32'd1);

        // Back-to-back frames, then one frame with random gaps.
        do_reset();
        send_frame(frame1, 13, 13, 1'b0, 1'b1);
        send_frame(frame1, 13, 13, 1'b0, 1'b1);
        send_frame(frame1, 13, 13, 1'b1, 1'b1);
        idle(1);
        check_counts();
        chk("t4_a_good_is_3", 32'(a_good), 32'd3);

        // Reset after 6 bytes; the aborted frame must never report.
        do_reset();
        send_frame(frame1, 13, 6, 1'b0, 1'b1);
        do_reset();
        send_frame(frame1, 13, 13, 1'b0, 1'b1);
        idle(1);
        check_counts();

        // Five corrupt frames: B's 2-bit bad counter saturates at 3.
        do_reset();
        for (int n = 0; n < 5; n++) send_frame(frame_bad, 13, 13, 1'b0, 1'b0);
        idle(1);
        check_counts();
        chk("b_bad_sat", 32'(b_bad), 32'd3);
        chk("a_bad_5",   32'(a_bad), 32'd5);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
